// File: rtl/flap_controller.sv
// flap_controller
//   Motion sequencer for the 16-light bird column. It turns a synchronized
//   flap button and a gravity timebase into one-cycle step pulses. L moves
//   the bird up and R moves it down. The column's one-hot lights vector is
//   read back to clamp at the ceiling and to detect ground contact.
//
//   Parameters
//     TICK_DIV   clock cycles per motion step (>= 2)
//     FLAP_STEPS up-steps issued per flap press (>= 1)
//
//   Ports
//     Clock   in   system clock, rising-edge
//     RST     in   asynchronous reset, active-low
//     enable  in   game running (level)
//     flap    in   flap button, already synchronized, active-high
//     lights  in   [15:0] bird position, one-hot, bit 15 = top, bit 0 = ground
//     L       out  registered one-cycle pulse, step toward lights[15]
//     R       out  registered one-cycle pulse, step toward lights[0]
//     landed  out  registered, high while the bird is on the ground
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | game stopped; outputs low, tick counter held at 0
//   FALL  | gravity; one R pulse per tick until ground is touched
//   RISE  | flap burst; one L pulse per tick, FLAP_STEPS ticks, then FALL
//   DEAD  | bird on the ground; landed high until enable drops

module flap_controller #(
    parameter int TICK_DIV   = 4,
    parameter int FLAP_STEPS = 3
) (
    input  logic        Clock,
    input  logic        RST,
    input  logic        enable,
    input  logic        flap,
    input  logic [15:0] lights,
    output logic        L,
    output logic        R,
    output logic        landed
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (FLAP_STEPS > 0) ? $clog2(FLAP_STEPS + 1) : 1;
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEPS_INIT = SW'(FLAP_STEPS);
    localparam logic [SW-1:0] STEPS_ONE  = SW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        RISE = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [SW-1:0] steps;
    logic [SW-1:0] steps_nxt;
    logic          flap_q;
    logic          press;
    logic          active;
    logic          tick;
    logic          l_nxt;
    logic          r_nxt;
    logic          landed_nxt;

    // flap_q resets to 1 so a button held through reset is not seen as a press
    assign press  = flap & ~flap_q;
    assign active = (state == FALL) || (state == RISE);
    assign tick   = active && (cnt == TICK_LAST);

    // State register
    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; enable low overrides everything
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = FALL;
                FALL: begin
                    if (press) begin
                        state_nxt = RISE;
                    end else if (tick && lights[0]) begin
                        state_nxt = DEAD;
                    end
                end
                RISE: begin
                    if (press) begin
                        state_nxt = RISE;
                    end else if (tick && (steps == STEPS_ONE)) begin
                        state_nxt = FALL;
                    end
                end
                DEAD:    state_nxt = DEAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic. A press on a tick edge takes priority and suppresses the
    // pulse. At the ceiling the up-step is consumed without a pulse.
    always_comb begin
        l_nxt      = 1'b0;
        r_nxt      = 1'b0;
        landed_nxt = (state_nxt == DEAD);
        if (enable && !press && tick) begin
            if (state == FALL) begin
                r_nxt = ~lights[0];
            end
            if (state == RISE) begin
                l_nxt = ~lights[15];
            end
        end
    end

    // Tick and step counters. The tick counter returns to 0 on a press, on a
    // tick and whenever the FSM is outside FALL/RISE. That covers every entry
    // into an active state.
    always_comb begin
        cnt_nxt   = '0;
        steps_nxt = steps;
        if (!enable) begin
            steps_nxt = '0;
        end else if (active) begin
            if (press) begin
                steps_nxt = STEPS_INIT;
            end else if (tick) begin
                if (state == RISE) begin
                    steps_nxt = steps - STEPS_ONE;
                end
            end else begin
                cnt_nxt = cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            flap_q <= 1'b1;
            cnt    <= '0;
            steps  <= '0;
            L      <= 1'b0;
            R      <= 1'b0;
            landed <= 1'b0;
        end else begin
            flap_q <= flap;
            cnt    <= cnt_nxt;
            steps  <= steps_nxt;
            L      <= l_nxt;
            R      <= r_nxt;
            landed <= landed_nxt;
        end
    end

endmodule

// File: tb/tb_flap_controller.sv
// tb_flap_controller
//   Bench for flap_controller (TICK_DIV=4, FLAP_STEPS=3). A reference model
//   schedules pulses by absolute edge number: the edge at which the next
//   step falls due, plus the number of up-steps left in the current burst.
//   Directed scenarios come first, then randomized traffic.

module tb_flap_controller;

    localparam int TD = 4;
    localparam int FS = 3;

    logic        Clock  = 1'b0;
    logic        RST    = 1'b0;
    logic        enable = 1'b0;
    logic        flap   = 1'b1;
    logic [15:0] lights = 16'h0100;
    logic        L;
    logic        R;
    logic        landed;

    flap_controller #(
        .TICK_DIV   (TD),
        .FLAP_STEPS (FS)
    ) dut (
        .Clock  (Clock),
        .RST    (RST),
        .enable (enable),
        .flap   (flap),
        .lights (lights),
        .L      (L),
        .R      (R),
        .landed (landed)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    typedef enum {M_IDLE, M_RUN, M_DEAD} mode_t;
    mode_t m_mode  = M_IDLE;
    int    edge_n  = 0;
    int    due     = 0;
    int    ups     = 0;
    bit    fl_prev = 1'b1;
    bit    exp_L      = 1'b0;
    bit    exp_R      = 1'b0;
    bit    exp_landed = 1'b0;
    int    seen_L  = 0;
    int    seen_R  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_IDLE;
        fl_prev    = 1'b1;
        ups        = 0;
        exp_L      = 1'b0;
        exp_R      = 1'b0;
        exp_landed = 1'b0;
    endtask

    // One rising edge of the model, using the inputs sampled at that edge.
    task automatic model_edge();
        bit press;
        press   = flap && !fl_prev;
        fl_prev = flap;
        exp_L   = 1'b0;
        exp_R   = 1'b0;
        if (!enable) begin
            m_mode = M_IDLE;
            ups    = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_RUN;
                    due    = edge_n + TD;
                    ups    = 0;
                end
                M_RUN: begin
                    if (press) begin
                        ups = FS;
                        due = edge_n + TD;
                    end else if (edge_n == due) begin
                        if (ups > 0) begin
                            exp_L = !lights[15];
                            ups--;
                            due += TD;
                        end else if (lights[0]) begin
                            m_mode = M_DEAD;
                        end else begin
                            exp_R = 1'b1;
                            due += TD;
                        end
                    end
                end
                default: ;
            endcase
        end
        exp_landed = (m_mode == M_DEAD);
    endtask

    task automatic step(input bit en, input bit fl, input logic [15:0] li);
        enable = en;
        flap   = fl;
        lights = li;
        @(posedge Clock);
        edge_n++;
        model_edge();
        #1;
        check_val("L", int'(L), int'(exp_L));
        check_val("R", int'(R), int'(exp_R));
        check_val("landed", int'(landed), int'(exp_landed));
        check_val("L_R_exclusive", int'(L && R), 0);
        seen_L += int'(L);
        seen_R += int'(R);
    endtask

    // Reset pulse placed between edges; the outputs must drop at once.
    task automatic async_reset();
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_val("rst_L", int'(L), 0);
        check_val("rst_R", int'(R), 0);
        check_val("rst_landed", int'(landed), 0);
        #1;
        RST = 1'b1;
    endtask

    function automatic logic [15:0] pick_lights();
        logic [15:0] v;
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) begin
            v = 16'h0001;
        end else if (r < 4) begin
            v = 16'h8000;
        end else begin
            v = 16'h0001 << $urandom_range(1, 14);
        end
        return v;
    endfunction

    initial begin
        logic [15:0] li;
        bit          en;

        // reset held with the button down
        #12;
        check_val("reset_L", int'(L), 0);
        check_val("reset_R", int'(R), 0);
        check_val("reset_landed", int'(landed), 0);
        model_reset();
        RST = 1'b1;

        // button held through reset: no RISE, R every 4 edges
        seen_L = 0;
        seen_R = 0;
        repeat (13) step(1'b1, 1'b1, 16'h0100);
        check_val("held_flap_L_count", seen_L, 0);
        check_val("held_flap_R_count", seen_R, 3);

        repeat (2) step(1'b1, 1'b0, 16'h0100);

        // single press mid-FALL: three L then one R within 16 edges
        step(1'b1, 1'b1, 16'h0100);
        seen_L = 0;
        seen_R = 0;
        repeat (16) step(1'b1, 1'b0, 16'h0100);
        check_val("burst_L_count", seen_L, 3);
        check_val("burst_R_count", seen_R, 1);
        check_val("burst_R_last", int'(R), 1);

        // press at the ceiling: steps consumed without L
        step(1'b1, 1'b1, 16'h8000);
        seen_L = 0;
        seen_R = 0;
        repeat (16) step(1'b1, 1'b0, 16'h8000);
        check_val("ceiling_L_count", seen_L, 0);
        check_val("ceiling_R_count", seen_R, 1);

        // press landing on a tick edge
        for (int i = 0; i < 8 && due != edge_n + 1; i++) begin
            step(1'b1, 1'b0, 16'h0100);
        end
        check_val("tick_align", due, edge_n + 1);
        step(1'b1, 1'b1, 16'h0100);
        check_val("tick_press_R", int'(R), 0);
        seen_L = 0;
        repeat (4) step(1'b1, 1'b0, 16'h0100);
        check_val("tick_press_L_at_4", int'(L), 1);
        check_val("tick_press_L_count", seen_L, 1);

        // ground contact, presses ignored, enable drop, re-enable
        repeat (20) step(1'b1, 1'b0, 16'h0001);
        check_val("ground_landed", int'(landed), 1);
        step(1'b1, 1'b1, 16'h0001);
        repeat (6) step(1'b1, 1'b0, 16'h0001);
        check_val("dead_press_ignored", int'(landed), 1);
        step(1'b0, 1'b0, 16'h0001);
        check_val("disable_landed", int'(landed), 0);
        seen_R = 0;
        repeat (5) step(1'b1, 1'b0, 16'h0100);
        check_val("reenable_R", int'(R), 1);
        check_val("reenable_R_count", seen_R, 1);

        // enable dropped mid-RISE
        step(1'b1, 1'b1, 16'h0100);
        repeat (5) step(1'b1, 1'b0, 16'h0100);
        step(1'b0, 1'b0, 16'h0100);
        check_val("drop_L", int'(L), 0);
        check_val("drop_R", int'(R), 0);

        // reset asserted right after an L pulse mid-RISE
        step(1'b1, 1'b0, 16'h0100);
        step(1'b1, 1'b1, 16'h0100);
        repeat (4) step(1'b1, 1'b0, 16'h0100);
        check_val("pre_reset_L", int'(L), 1);
        async_reset();

        // randomized traffic
        li = 16'h0100;
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) li = pick_lights();
            if ($urandom_range(0, 99) == 0) en = !en;
            if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            step(en, ($urandom_range(0, 5) == 0), li);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
